// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback stage of the five-stage MIPS pipeline. It registers the M-stage
// result, does load byte/half extraction and extension before the register,
// picks the GRF write value and drives the GRF write port. The same registered
// A3/WD3/WE3 are used by the forwarding network. It also counts retired
// (valid, captured) instructions.
//
// Ports
//   Clk, Reset      rising-edge clock, synchronous active-high reset
//   M_Valid_In      M stage holds a real instruction (0 = bubble)
//   M_Pc_In         word-index PC (byte address = 32'h3000 + (Pc << 2))
//   M_We3_In        instruction writes a GPR
//   M_A3_In         destination register
//   M_Wsel_In       write source: 0 ALU, 1 memory, 2 link, 3 ALU
//   M_Alu_In        ALU/MDU result
//   M_Mem_In        aligned word read from data memory
//   M_Addr_Lo_In    low two bits of the load byte address
//   M_Ld_Type_In    0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu, 5-7 lw
//   Flush_In        capture a bubble instead of the M instruction
//   Pc_Out          W-stage PC
//   A3_Out          GRF write address (0 when no write)
//   Wd3_Out         GRF write data (0 when no write)
//   We3_Out         GRF write enable ($0 writes already suppressed)
//   Retire_Cnt_Out  valid instructions captured since reset (wraps)
//
// Optional feature: define WB_TRACE_EN to print a write trace line for each
// GRF write. Hardware behaviour is identical with or without it.
// -----------------------------------------------------------------------------
module wb_stage (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        M_Valid_In,
   input  logic [31:0] M_Pc_In,
   input  logic        M_We3_In,
   input  logic [4:0]  M_A3_In,
   input  logic [1:0]  M_Wsel_In,
   input  logic [31:0] M_Alu_In,
   input  logic [31:0] M_Mem_In,
   input  logic [1:0]  M_Addr_Lo_In,
   input  logic [2:0]  M_Ld_Type_In,
   input  logic        Flush_In,
   output logic [31:0] Pc_Out,
   output logic [4:0]  A3_Out,
   output logic [31:0] Wd3_Out,
   output logic        We3_Out,
   output logic [31:0] Retire_Cnt_Out
);

   logic [31:0] pc_q, pc_d;
   logic [4:0]  a3_q, a3_d;
   logic [31:0] wd3_q, wd3_d;
   logic        we3_q, we3_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;

   logic        capture_s;
   logic        we_eff_s;
   logic [31:0] load_s;
   logic [31:0] link_s;
   logic [31:0] src_s;

   // Byte/half selection and extension of the aligned load word.
   function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  ty);
      logic [7:0]  b;
      logic [15:0] h;
      case (lo)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = word[7:0];
      endcase
      // Half select ignores lo[0]; misaligned halves are not trapped here.
      if (lo[1]) begin
         h = word[31:16];
      end else begin
         h = word[15:0];
      end
      case (ty)
         3'd1:    extract_load = {{24{b[7]}}, b};
         3'd2:    extract_load = {24'd0, b};
         3'd3:    extract_load = {{16{h[15]}}, h};
         3'd4:    extract_load = {16'd0, h};
         default: extract_load = word;
      endcase
   endfunction

   // Next-state: source selection, $0 suppression, bubble handling, counter.
   always_comb begin
      capture_s    = M_Valid_In & ~Flush_In;
      we_eff_s     = M_We3_In & (M_A3_In != 5'd0);
      load_s       = extract_load(M_Mem_In, M_Addr_Lo_In, M_Ld_Type_In);
      // Link address wraps mod 2^32 naturally in 32-bit arithmetic.
      link_s       = 32'h0000_3000 + ((M_Pc_In + 32'd2) << 2);
      case (M_Wsel_In)
         2'd1:    src_s = load_s;
         2'd2:    src_s = link_s;
         default: src_s = M_Alu_In;
      endcase
      pc_d         = 32'd0;
      a3_d         = 5'd0;
      wd3_d        = 32'd0;
      we3_d        = 1'b0;
      retire_cnt_d = retire_cnt_q;
      if (capture_s) begin
         pc_d         = M_Pc_In;
         we3_d        = we_eff_s;
         retire_cnt_d = retire_cnt_q + 32'd1;
         if (we_eff_s) begin
            a3_d  = M_A3_In;
            wd3_d = src_s;
         end else begin
            a3_d  = 5'd0;
            wd3_d = 32'd0;
         end
      end else begin
         pc_d         = 32'd0;
         we3_d        = 1'b0;
         retire_cnt_d = retire_cnt_q;
      end
   end

   // W-stage registers; reset wins over flush and capture.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q         <= 32'd0;
         a3_q         <= 5'd0;
         wd3_q        <= 32'd0;
         we3_q        <= 1'b0;
         retire_cnt_q <= 32'd0;
      end else begin
         pc_q         <= pc_d;
         a3_q         <= a3_d;
         wd3_q        <= wd3_d;
         we3_q        <= we3_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign Pc_Out         = pc_q;
   assign A3_Out         = a3_q;
   assign Wd3_Out        = wd3_q;
   assign We3_Out        = we3_q;
   assign Retire_Cnt_Out = retire_cnt_q;

`ifdef WB_TRACE_EN
   // Trace of the write the GRF commits at this edge.
   always @(posedge Clk) begin
      if (!Reset && we3_q) begin
         $display("%d@%h: $%d <= %h", $time, 32'h0000_3000 + (pc_q << 2), a3_q, wd3_q);
      end
   end
`else
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   logic        clk;
   logic        reset;
   logic        m_valid;
   logic [31:0] m_pc;
   logic        m_we3;
   logic [4:0]  m_a3;
   logic [1:0]  m_wsel;
   logic [31:0] m_alu;
   logic [31:0] m_mem;
   logic [1:0]  m_lo;
   logic [2:0]  m_ld;
   logic        flush;
   logic [31:0] pc_o;
   logic [4:0]  a3_o;
   logic [31:0] wd3_o;
   logic        we3_o;
   logic [31:0] cnt_o;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic        we;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   string       name_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] cnt_m    = 32'd0;

   wb_stage dut (
      .Clk            (clk),
      .Reset          (reset),
      .M_Valid_In     (m_valid),
      .M_Pc_In        (m_pc),
      .M_We3_In       (m_we3),
      .M_A3_In        (m_a3),
      .M_Wsel_In      (m_wsel),
      .M_Alu_In       (m_alu),
      .M_Mem_In       (m_mem),
      .M_Addr_Lo_In   (m_lo),
      .M_Ld_Type_In   (m_ld),
      .Flush_In       (flush),
      .Pc_Out         (pc_o),
      .A3_Out         (a3_o),
      .Wd3_Out        (wd3_o),
      .We3_Out        (we3_o),
      .Retire_Cnt_Out (cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
      end
   endtask

   // Monitor: W outputs are valid 1 time unit after every edge that had stimulus queued.
   always @(posedge clk) begin
      exp_t  e;
      string nm;
      #1;
      if (sb_q.size() != 0) begin
         e  = sb_q.pop_front();
         nm = name_q.pop_front();
         chk(nm, "pc",  pc_o,           e.pc);
         chk(nm, "a3",  {27'd0, a3_o},  {27'd0, e.a3});
         chk(nm, "wd3", wd3_o,          e.wd);
         chk(nm, "we3", {31'd0, we3_o}, {31'd0, e.we});
         chk(nm, "cnt", cnt_o,          e.cnt);
      end
   end

   // Drive one M-stage slot at a negedge; expected W values are pushed here.
   task automatic issue(input string nm, input logic rst, input logic fl, input logic vld,
                        input logic we, input logic [4:0] a3, input logic [1:0] wsel,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [1:0] lo,
                        input logic [2:0] ld, input logic [31:0] pc,
                        input logic exp_we, input logic [4:0] exp_a3, input logic [31:0] exp_wd);
      exp_t e;
      reset = rst; flush = fl; m_valid = vld; m_we3 = we; m_a3 = a3; m_wsel = wsel;
      m_alu = alu; m_mem = mem; m_lo = lo; m_ld = ld; m_pc = pc;
      if (rst) begin
         cnt_m = 32'd0;
         e.pc  = 32'd0;
      end else if (vld && !fl) begin
         cnt_m = cnt_m + 32'd1;
         e.pc  = pc;
      end else begin
         e.pc  = 32'd0;
      end
      e.we  = exp_we;
      e.a3  = exp_a3;
      e.wd  = exp_wd;
      e.cnt = cnt_m;
      sb_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
   endtask

   localparam logic [31:0] MEMW = 32'h80FF_7F01;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; m_valid = 1'b0; m_we3 = 1'b0; m_a3 = 5'd0; m_wsel = 2'd0;
      m_alu = 32'd0; m_mem = 32'd0; m_lo = 2'd0; m_ld = 3'd0; m_pc = 32'd0;
      //       name        rst  fl   vld  we   a3     wsel  alu            mem   lo    ld    pc             ewe  ea3    ewd
      issue("reset0",     1'b1,1'b0,1'b0,1'b0,5'd0, 2'd0, 32'd0,         32'd0,2'd0, 3'd0, 32'd0,         1'b0,5'd0, 32'd0);
      issue("reset1",     1'b1,1'b0,1'b0,1'b0,5'd0, 2'd0, 32'd0,         32'd0,2'd0, 3'd0, 32'd0,         1'b0,5'd0, 32'd0);
      issue("addu",       1'b0,1'b0,1'b1,1'b1,5'd8, 2'd0, 32'h12345678,  32'd0,2'd0, 3'd0, 32'd4,         1'b1,5'd8, 32'h12345678);
      issue("lb3",        1'b0,1'b0,1'b1,1'b1,5'd9, 2'd1, 32'd0,         MEMW, 2'd3, 3'd1, 32'd5,         1'b1,5'd9, 32'hFFFFFF80);
      issue("lbu2",       1'b0,1'b0,1'b1,1'b1,5'd9, 2'd1, 32'd0,         MEMW, 2'd2, 3'd2, 32'd6,         1'b1,5'd9, 32'h000000FF);
      issue("lh2",        1'b0,1'b0,1'b1,1'b1,5'd9, 2'd1, 32'd0,         MEMW, 2'd2, 3'd3, 32'd7,         1'b1,5'd9, 32'hFFFF80FF);
      issue("lhu1",       1'b0,1'b0,1'b1,1'b1,5'd9, 2'd1, 32'd0,         MEMW, 2'd1, 3'd4, 32'd8,         1'b1,5'd9, 32'h00007F01);
      issue("ld6",        1'b0,1'b0,1'b1,1'b1,5'd9, 2'd1, 32'd0,         MEMW, 2'd2, 3'd6, 32'd9,         1'b1,5'd9, 32'h80FF7F01);
      issue("lh3",        1'b0,1'b0,1'b1,1'b1,5'd9, 2'd1, 32'd0,         MEMW, 2'd3, 3'd3, 32'd10,        1'b1,5'd9, 32'hFFFF80FF);
      issue("lb0",        1'b0,1'b0,1'b1,1'b1,5'd9, 2'd1, 32'd0,         MEMW, 2'd0, 3'd1, 32'd11,        1'b1,5'd9, 32'h00000001);
      issue("lb1",        1'b0,1'b0,1'b1,1'b1,5'd9, 2'd1, 32'd0,         MEMW, 2'd1, 3'd1, 32'd12,        1'b1,5'd9, 32'h0000007F);
      issue("lw0",        1'b0,1'b0,1'b1,1'b1,5'd9, 2'd1, 32'd0,         MEMW, 2'd3, 3'd0, 32'd13,        1'b1,5'd9, 32'h80FF7F01);
      issue("jal",        1'b0,1'b0,1'b1,1'b1,5'd31,2'd2, 32'd0,         32'd0,2'd0, 3'd0, 32'd5,         1'b1,5'd31,32'h0000301C);
      issue("jal_wrap",   1'b0,1'b0,1'b1,1'b1,5'd31,2'd2, 32'd0,         32'd0,2'd0, 3'd0, 32'hFFFFFFFF,  1'b1,5'd31,32'h00003004);
      issue("wsel3",      1'b0,1'b0,1'b1,1'b1,5'd2, 2'd3, 32'hAAAA5555,  MEMW, 2'd0, 3'd1, 32'd6,         1'b1,5'd2, 32'hAAAA5555);
      issue("wr_zero",    1'b0,1'b0,1'b1,1'b1,5'd0, 2'd0, 32'd5,         32'd0,2'd0, 3'd0, 32'd7,         1'b0,5'd0, 32'd0);
      issue("no_we",      1'b0,1'b0,1'b1,1'b0,5'd4, 2'd0, 32'h77,        32'd0,2'd0, 3'd0, 32'd8,         1'b0,5'd0, 32'd0);
      issue("flush",      1'b0,1'b1,1'b1,1'b1,5'd3, 2'd0, 32'h55,        32'd0,2'd0, 3'd0, 32'd9,         1'b0,5'd0, 32'd0);
      issue("bubble",     1'b0,1'b0,1'b0,1'b1,5'd3, 2'd0, 32'h55,        32'd0,2'd0, 3'd0, 32'd9,         1'b0,5'd0, 32'd0);
      issue("b2b_a",      1'b0,1'b0,1'b1,1'b1,5'd1, 2'd0, 32'h11,        32'd0,2'd0, 3'd0, 32'd20,        1'b1,5'd1, 32'h11);
      issue("b2b_b",      1'b0,1'b0,1'b1,1'b1,5'd2, 2'd0, 32'h22,        32'd0,2'd0, 3'd0, 32'd21,        1'b1,5'd2, 32'h22);
      issue("rst_flush",  1'b1,1'b1,1'b1,1'b1,5'd8, 2'd0, 32'h99,        32'd0,2'd0, 3'd0, 32'd22,        1'b0,5'd0, 32'd0);
      issue("after_rst",  1'b0,1'b0,1'b1,1'b1,5'd8, 2'd0, 32'h99,        32'd0,2'd0, 3'd0, 32'd23,        1'b1,5'd8, 32'h99);
      issue("rst_mid",    1'b1,1'b0,1'b1,1'b1,5'd8, 2'd0, 32'h98,        32'd0,2'd0, 3'd0, 32'd24,        1'b0,5'd0, 32'd0);
      // Preload the counter to its maximum so the next capture wraps it.
      force dut.retire_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt_q;
      cnt_m = 32'hFFFF_FFFF;
      issue("cnt_wrap",   1'b0,1'b0,1'b1,1'b1,5'd5, 2'd0, 32'h5A,        32'd0,2'd0, 3'd0, 32'd30,        1'b1,5'd5, 32'h5A);
      issue("cnt_after",  1'b0,1'b0,1'b1,1'b1,5'd6, 2'd0, 32'h6B,        32'd0,2'd0, 3'd0, 32'd31,        1'b1,5'd6, 32'h6B);
      m_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks = n_checks + 1;
      if (sb_q.size() == 0) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
